// File: rtl/bouncing_box_gen.sv
// Bouncing box pixel source: a square box on a solid background that moves one step per frame.
// Optional COLOR_CYCLE_EN: the box colour rotates {g,b,r} on every frame where the box bounces.
module bouncing_box_gen #(
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter int          BOX_SIZE  = 32,
  parameter int          SPEED     = 2,
  parameter logic [11:0] BOX_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR  = 12'h137
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pix_en,
  input  logic [9:0] i_h_count,
  input  logic [9:0] i_v_count,
  input  logic       i_video_on,
  input  logic       i_start,
  input  logic       i_pause,
  output logic [3:0] o_out_r,
  output logic [3:0] o_out_g,
  output logic [3:0] o_out_b,
  output logic [9:0] o_box_x,
  output logic [9:0] o_box_y,
  output logic       o_moving
);

  localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] SPD    = 11'(SPEED);
  localparam logic [10:0] BSZ    = 11'(BOX_SIZE);
  localparam logic [9:0]  X_HOME = 10'((H_ACTIVE - BOX_SIZE) / 2);
  localparam logic [9:0]  Y_HOME = 10'((V_ACTIVE - BOX_SIZE) / 2);

  typedef enum logic {HOLD, MOVE} state_t;

  state_t      r_state, w_state_nxt;
  logic [9:0]  r_box_x, r_box_y;
  logic        r_x_right, r_y_down;
  logic [11:0] r_color;
  logic [11:0] w_box_color;

  logic        w_frame_tick, w_update;
  logic [10:0] w_x_sum, w_y_sum;
  logic [9:0]  w_x_next, w_y_next;
  logic        w_x_flip, w_y_flip;
  logic [10:0] w_h11, w_v11, w_bx11, w_by11;
  logic        w_in_box;

  // First blanking line, first pixel: the box may move without tearing a visible frame.
  assign w_frame_tick = i_pix_en && (i_h_count == 10'd0) && (i_v_count == 10'(V_ACTIVE));
  assign w_update     = w_frame_tick && (r_state == MOVE) && !i_pause;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= HOLD;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HOLD:    if (i_start && !i_pause) w_state_nxt = MOVE;
      MOVE:    if (i_pause)             w_state_nxt = HOLD;
      default: w_state_nxt = HOLD;
    endcase
  end

  // Per-axis next position; comparisons in 11 bits so the sum cannot wrap.
  always_comb begin
    w_x_sum  = {1'b0, r_box_x} + SPD;
    w_x_next = r_box_x;
    w_x_flip = 1'b0;
    if (r_x_right) begin
      if (w_x_sum >= X_MAX) begin
        w_x_next = X_MAX[9:0];
        w_x_flip = 1'b1;
      end else begin
        w_x_next = w_x_sum[9:0];
      end
    end else begin
      if ({1'b0, r_box_x} <= SPD) begin
        w_x_next = 10'd0;
        w_x_flip = 1'b1;
      end else begin
        w_x_next = r_box_x - SPD[9:0];
      end
    end
  end

  always_comb begin
    w_y_sum  = {1'b0, r_box_y} + SPD;
    w_y_next = r_box_y;
    w_y_flip = 1'b0;
    if (r_y_down) begin
      if (w_y_sum >= Y_MAX) begin
        w_y_next = Y_MAX[9:0];
        w_y_flip = 1'b1;
      end else begin
        w_y_next = w_y_sum[9:0];
      end
    end else begin
      if ({1'b0, r_box_y} <= SPD) begin
        w_y_next = 10'd0;
        w_y_flip = 1'b1;
      end else begin
        w_y_next = r_box_y - SPD[9:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_box_x   <= X_HOME;
      r_box_y   <= Y_HOME;
      r_x_right <= 1'b1;
      r_y_down  <= 1'b1;
    end else if (w_update) begin
      r_box_x   <= w_x_next;
      r_box_y   <= w_y_next;
      r_x_right <= r_x_right ^ w_x_flip;
      r_y_down  <= r_y_down  ^ w_y_flip;
    end
  end

`ifdef COLOR_CYCLE_EN
  logic [11:0] r_box_color;

  // A corner hit flips both axes but rotates only once.
  always_ff @(posedge i_clk) begin
    if (i_reset)                            r_box_color <= BOX_COLOR;
    else if (w_update && (w_x_flip || w_y_flip)) r_box_color <= {r_box_color[7:0], r_box_color[11:8]};
  end

  assign w_box_color = r_box_color;
`else
  assign w_box_color = BOX_COLOR;
`endif

  assign w_h11  = {1'b0, i_h_count};
  assign w_v11  = {1'b0, i_v_count};
  assign w_bx11 = {1'b0, r_box_x};
  assign w_by11 = {1'b0, r_box_y};
  assign w_in_box = (w_h11 >= w_bx11) && (w_h11 < w_bx11 + BSZ) &&
                    (w_v11 >= w_by11) && (w_v11 < w_by11 + BSZ);

  always_ff @(posedge i_clk) begin
    if (i_reset)       r_color <= 12'h000;
    else if (i_pix_en) r_color <= !i_video_on ? 12'h000 : (w_in_box ? w_box_color : BG_COLOR);
  end

  assign o_out_r  = r_color[11:8];
  assign o_out_g  = r_color[7:4];
  assign o_out_b  = r_color[3:0];
  assign o_box_x  = r_box_x;
  assign o_box_y  = r_box_y;
  assign o_moving = (r_state == MOVE);

endmodule

// File: tb/tb_bouncing_box_gen.sv
// Directed bench for bouncing_box_gen: pixel vector table plus motion, bounce, corner and reset sequences.
module tb_bouncing_box_gen;

  logic       clk = 1'b0;
  logic       reset, pix_en, video_on, start, pause;
  logic [9:0] h_count, v_count;

  logic [3:0] r_a, g_a, b_a, r_c, g_c, b_c;
  logic [9:0] bx_a, by_a, bx_c, by_c;
  logic       mv_a, mv_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bouncing_box_gen dut (
    .i_clk(clk), .i_reset(reset), .i_pix_en(pix_en), .i_h_count(h_count), .i_v_count(v_count),
    .i_video_on(video_on), .i_start(start), .i_pause(pause),
    .o_out_r(r_a), .o_out_g(g_a), .o_out_b(b_a), .o_box_x(bx_a), .o_box_y(by_a), .o_moving(mv_a)
  );

  // Square field so both axes start at 224 and hit their far edges on the same tick.
  bouncing_box_gen #(.H_ACTIVE(480), .V_ACTIVE(480), .BOX_COLOR(12'hF00)) dut_c (
    .i_clk(clk), .i_reset(reset), .i_pix_en(pix_en), .i_h_count(h_count), .i_v_count(v_count),
    .i_video_on(video_on), .i_start(start), .i_pause(pause),
    .o_out_r(r_c), .o_out_g(g_c), .o_out_b(b_c), .o_box_x(bx_c), .o_box_y(by_c), .o_moving(mv_c)
  );

  typedef struct {
    string       name;
    logic        pen;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        von;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_tick();
    pix_en = 1'b1; h_count = 10'd0; v_count = 10'd480; video_on = 1'b0;
    step();
    pix_en = 1'b0; h_count = 10'd1; v_count = 10'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; pix_en = 1'b0; video_on = 1'b0; start = 1'b0; pause = 1'b0;
    h_count = 10'd1; v_count = 10'd0;

    vecs[0] = '{"box_topleft",  1'b1, 10'd304, 10'd224, 1'b1, 12'hFFF};
    vecs[1] = '{"bg_origin",    1'b1, 10'd0,   10'd0,   1'b1, 12'h137};
    vecs[2] = '{"box_botright", 1'b1, 10'd335, 10'd255, 1'b1, 12'hFFF};
    vecs[3] = '{"right_of_box", 1'b1, 10'd336, 10'd255, 1'b1, 12'h137};
    vecs[4] = '{"blanked",      1'b1, 10'd304, 10'd224, 1'b0, 12'h000};
    vecs[5] = '{"pix_en_hold",  1'b0, 10'd304, 10'd224, 1'b1, 12'h000};
    vecs[6] = '{"left_of_box",  1'b1, 10'd303, 10'd224, 1'b1, 12'h137};
    vecs[7] = '{"below_box",    1'b1, 10'd304, 10'd256, 1'b1, 12'h137};
    vecs[8] = '{"above_box",    1'b1, 10'd304, 10'd223, 1'b1, 12'h137};
    vecs[9] = '{"last_pixel",   1'b1, 10'd639, 10'd479, 1'b1, 12'h137};

    step(); step();
    chk("rst_out",    {r_a, g_a, b_a}, 12'h000);
    chk("rst_box_x",  bx_a, 304);
    chk("rst_box_y",  by_a, 224);
    chk("rst_moving", mv_a, 0);
    chk("rst_c_xy",   {bx_c, by_c}, {10'd224, 10'd224});
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      pix_en = vecs[i].pen; h_count = vecs[i].h; v_count = vecs[i].v; video_on = vecs[i].von;
      step();
      chk(vecs[i].name, {r_a, g_a, b_a}, vecs[i].exp);
    end
    pix_en = 1'b0; h_count = 10'd1; v_count = 10'd0;

    // start and pause together: pause wins
    start = 1'b1; pause = 1'b1; step();
    start = 1'b0; pause = 1'b0;
    chk("start_pause_same", mv_a, 0);

    start = 1'b1; step(); start = 1'b0;
    chk("start_moving", mv_a, 1);

    // pause on the tick cycle suppresses the move
    pause = 1'b1; frame_tick(); pause = 1'b0;
    chk("pause_tick_xy", {bx_a, by_a}, {10'd304, 10'd224});
    chk("pause_tick_mv", mv_a, 0);

    // tick without MOVE does nothing
    frame_tick();
    chk("hold_tick_xy", {bx_a, by_a}, {10'd304, 10'd224});

    start = 1'b1; step(); start = 1'b0;
    frame_tick();
    chk("tick1_xy", {bx_a, by_a}, {10'd306, 10'd226});
    chk("tick1_mv", mv_a, 1);

    for (int t = 2; t <= 112; t++) frame_tick();
    chk("tick112_y_clamp", by_a, 448);
    chk("tick112_x",       bx_a, 528);
    chk("corner_xy",       {bx_c, by_c}, {10'd448, 10'd448});

    pix_en = 1'b1; h_count = 10'd448; v_count = 10'd448; video_on = 1'b1;
    step();
`ifdef COLOR_CYCLE_EN
    chk("corner_color", {r_c, g_c, b_c}, 12'h00F);
`else
    chk("corner_color", {r_c, g_c, b_c}, 12'hF00);
`endif
    h_count = 10'd447; step();
    chk("corner_bg", {r_c, g_c, b_c}, 12'h137);
    pix_en = 1'b0; h_count = 10'd1; v_count = 10'd0;

    frame_tick();
    chk("tick113_y_back", by_a, 446);
    chk("corner_flip_xy", {bx_c, by_c}, {10'd446, 10'd446});

    for (int t = 114; t <= 152; t++) frame_tick();
    chk("tick152_x_clamp", bx_a, 608);
    chk("tick152_y",       by_a, 368);
    frame_tick();
    chk("tick153_xy", {bx_a, by_a}, {10'd606, 10'd366});

    // reset mid-frame while moving, with start also high
    pix_en = 1'b1; h_count = 10'd100; v_count = 10'd100; video_on = 1'b1; start = 1'b1;
    reset = 1'b1; step();
    chk("midrst_xy",  {bx_a, by_a}, {10'd304, 10'd224});
    chk("midrst_out", {r_a, g_a, b_a}, 12'h000);
    chk("midrst_mv",  mv_a, 0);
    reset = 1'b0; start = 1'b0; pix_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
